// File: rtl/serial_alu_seq.sv
// Digit-serial ALU sequencer: ADD/SUB/AND/OR/XOR over XLEN bits, one DIGIT_W digit per clock,
// with a length-extended second operand, early ADD termination and valid/ready handshakes.
module serial_alu_seq #(
    parameter int XLEN       = 32,
    parameter int DIGIT_W    = 4,
    parameter int NUM_DIGITS = XLEN / DIGIT_W,
    parameter int LEN_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       op,
    input  logic [LEN_W-1:0] len_digits,
    input  logic             word2_signed,
    input  logic [XLEN-1:0]  word1,
    input  logic [XLEN-1:0]  word2,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             err,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [LEN_W-1:0] K_LAST = LEN_W'(NUM_DIGITS - 1);

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [LEN_W-1:0]  k_q, k_d, len_q, len_d;
    logic [XLEN-1:0]   w1_q, w1_d, ext2_q, ext2_d, work_q, work_d;
    logic              cy_q, cy_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d, err_q, err_d;

    logic [LEN_W-1:0]  len_c_s;
    int                sign_pos_s;
    logic [XLEN-1:0]   ext2_s;
    int                kidx_s;
    logic [DIGIT_W-1:0] dig_a_s, dig_b_s, dig_bx_s, dig_r_s;
    logic [DIGIT_W:0]  sum_s;
    logic [XLEN-1:0]   res_full_s, res_sel_s, hi_mask_s;
    logic              last_s, early_s, arith_s, sign_b_s, ovf_s;

    // Clamp the active length and sign/zero-extend word2 above its most significant active digit.
    always_comb begin
        ext2_s = '0;
        if (len_digits > K_LAST) begin
            len_c_s = K_LAST;
        end else begin
            len_c_s = len_digits;
        end
        sign_pos_s = (int'(len_c_s) + 1) * DIGIT_W - 1;
        for (int i = 0; i < XLEN; i++) begin
            if (i <= sign_pos_s) begin
                ext2_s[i] = word2[i];
            end else if (word2_signed) begin
                ext2_s[i] = word2[sign_pos_s];
            end else begin
                ext2_s[i] = 1'b0;
            end
        end
    end

    // Digit datapath for the current index, plus completion and early-exit decisions.
    always_comb begin
        kidx_s   = int'(k_q);
        dig_a_s  = w1_q[kidx_s*DIGIT_W +: DIGIT_W];
        dig_b_s  = ext2_q[kidx_s*DIGIT_W +: DIGIT_W];
        if (op_q == OP_SUB) begin
            dig_bx_s = ~dig_b_s;
        end else begin
            dig_bx_s = dig_b_s;
        end
        sum_s = {1'b0, dig_a_s} + {1'b0, dig_bx_s} + {{DIGIT_W{1'b0}}, cy_q};
        case (op_q)
            OP_ADD, OP_SUB: dig_r_s = sum_s[DIGIT_W-1:0];
            OP_AND:         dig_r_s = dig_a_s & dig_b_s;
            OP_OR:          dig_r_s = dig_a_s | dig_b_s;
            OP_XOR:         dig_r_s = dig_a_s ^ dig_b_s;
            default:        dig_r_s = '0;
        endcase
        res_full_s = work_q;
        res_full_s[kidx_s*DIGIT_W +: DIGIT_W] = dig_r_s;
        last_s    = (k_q == K_LAST);
        hi_mask_s = {XLEN{1'b1}} << ((kidx_s + 1) * DIGIT_W);
        // Early exit is never taken on the last digit so its carry/overflow come from the full rule.
        early_s = (op_q == OP_ADD) && !last_s && (kidx_s >= int'(len_q)) &&
                  ((ext2_q & hi_mask_s) == '0) && !sum_s[DIGIT_W];
        if (early_s) begin
            res_sel_s = (res_full_s & ~hi_mask_s) | (w1_q & hi_mask_s);
        end else begin
            res_sel_s = res_full_s;
        end
        arith_s  = (op_q == OP_ADD) || (op_q == OP_SUB);
        sign_b_s = (op_q == OP_SUB) ? ~ext2_q[XLEN-1] : ext2_q[XLEN-1];
        ovf_s    = arith_s && (w1_q[XLEN-1] == sign_b_s) && (res_full_s[XLEN-1] != w1_q[XLEN-1]);
    end

    // Next-state and register-update logic of the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        k_d      = k_q;
        len_d    = len_q;
        w1_d     = w1_q;
        ext2_d   = ext2_q;
        work_d   = work_q;
        cy_d     = cy_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = op;
                    w1_d    = word1;
                    ext2_d  = ext2_s;
                    len_d   = len_c_s;
                    k_d     = '0;
                    work_d  = '0;
                    cy_d    = (op == OP_SUB);
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (op_q > OP_XOR) begin
                    result_d = '0;
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    zero_d   = 1'b0;
                    err_d    = 1'b1;
                    state_d  = S_DONE;
                end else if (early_s || last_s) begin
                    result_d = res_sel_s;
                    carry_d  = arith_s && !early_s && sum_s[DIGIT_W];
                    ovf_d    = !early_s && ovf_s;
                    zero_d   = (res_sel_s == '0);
                    err_d    = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    work_d = res_full_s;
                    cy_d   = sum_s[DIGIT_W];
                    k_d    = k_q + LEN_W'(1);
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            k_q      <= '0;
            len_q    <= '0;
            w1_q     <= '0;
            ext2_q   <= '0;
            work_q   <= '0;
            cy_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            k_q      <= k_d;
            len_q    <= len_d;
            w1_q     <= w1_d;
            ext2_q   <= ext2_d;
            work_q   <= work_d;
            cy_q     <= cy_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Randomized and directed bench for serial_alu_seq against an arithmetic reference model.
module tb_serial_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  op = 3'd0;
    logic [2:0]  len_digits = 3'd0;
    logic        word2_signed = 1'b0;
    logic [31:0] word1 = 32'd0;
    logic [31:0] word2 = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] result;
    logic        carry, overflow, zero, err, busy;

    int total = 0;
    int bad   = 0;

    serial_alu_seq dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .op(op), .len_digits(len_digits), .word2_signed(word2_signed),
        .word1(word1), .word2(word2), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .result(result), .carry(carry), .overflow(overflow), .zero(zero),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: operand extension and results from plain integer arithmetic.
    function automatic void model(input logic [2:0] m_op, input logic [31:0] w1, input logic [31:0] w2,
                                  input logic [2:0] len, input logic sgn,
                                  output logic [31:0] res, output logic c, output logic v,
                                  output logic z, output logic e, output int lat);
        int n;
        logic [31:0] mask, x2, lowm;
        logic [32:0] s;
        longint sa;
        n    = (int'(len) + 1) * 4;
        mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
        x2   = w2 & mask;
        if (sgn && w2[n-1]) x2 = x2 | ~mask;
        c = 1'b0; v = 1'b0; e = 1'b0; lat = 8; res = 32'd0;
        case (m_op)
            3'd0: begin
                s   = {1'b0, w1} + {1'b0, x2};
                res = s[31:0];
                c   = s[32];
                sa  = longint'($signed(w1)) + longint'($signed(x2));
                v   = (sa != longint'($signed(res)));
                for (int k = int'(len); k < 7; k++) begin
                    lowm = (32'h1 << ((k + 1) * 4)) - 32'h1;
                    s = {1'b0, w1 & lowm} + {1'b0, x2 & lowm};
                    if (((s >> ((k + 1) * 4)) == 33'd0) && ((x2 >> ((k + 1) * 4)) == 32'd0)) begin
                        lat = k + 1; c = 1'b0; v = 1'b0;
                        break;
                    end
                end
            end
            3'd1: begin
                res = w1 - x2;
                c   = (w1 >= x2);
                sa  = longint'($signed(w1)) - longint'($signed(x2));
                v   = (sa != longint'($signed(res)));
            end
            3'd2: res = w1 & x2;
            3'd3: res = w1 | x2;
            3'd4: res = w1 ^ x2;
            default: begin e = 1'b1; lat = 1; end
        endcase
        z = !e && (res == 32'd0);
    endfunction

    task automatic do_op(input string tag, input logic [2:0] t_op, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [2:0] len, input logic sgn);
        logic [31:0] er;
        logic ec, ev, ez, ee;
        int elat, cyc;
        model(t_op, w1, w2, len, sgn, er, ec, ev, ez, ee, elat);
        @(negedge clk);
        op = t_op; word1 = w1; word2 = w2; len_digits = len; word2_signed = sgn;
        req_valid = 1'b1; rsp_ready = 1'b0;
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        word1 = $urandom; word2 = $urandom; op = 3'($urandom); len_digits = 3'($urandom);
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ".latency"}, 32'(cyc), 32'(elat));
        chk({tag, ".result"}, result, er);
        chk({tag, ".flags"}, {27'd0, carry, overflow, zero, err, busy}, {27'd0, ec, ev, ez, ee, 1'b1});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, ".release"}, {30'd0, rsp_valid, req_ready}, {30'd0, 1'b0, 1'b1});
        chk({tag, ".kept"}, result, er);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_w1;
        int cyc;
        logic seen;

        #2;
        chk("reset.ctl", {29'd0, req_ready, rsp_valid, busy}, {29'd0, 1'b1, 1'b0, 1'b0});
        chk("reset.out", {result[27:0], carry, overflow, zero, err}, 32'd0);
        @(negedge clk); rst = 1'b0;

        do_op("t1_add_early2", 3'd0, 32'h0000_00FF, 32'h4, 3'd0, 1'b0);
        do_op("t2_add_early0", 3'd0, 32'h10, 32'h4, 3'd0, 1'b0);
        do_op("t3_add_sext", 3'd0, 32'h0, 32'h800, 3'd2, 1'b1);
        do_op("t3_add_zext", 3'd0, 32'h0, 32'h800, 3'd2, 1'b0);
        do_op("t4_sub_neg", 3'd1, 32'd5, 32'd7, 3'd7, 1'b0);
        do_op("t4_sub_zero", 3'd1, 32'd7, 32'd7, 3'd7, 1'b0);
        do_op("t5_add_ovf", 3'd0, 32'h7FFF_FFFF, 32'h1, 3'd7, 1'b0);
        do_op("t5_xor", 3'd4, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 3'd7, 1'b0);
        do_op("t5_rsvd", 3'd6, 32'h1234_5678, 32'h9, 3'd7, 1'b0);
        do_op("and_sext", 3'd2, 32'hDEAD_BEEF, 32'h0000_00A5, 3'd1, 1'b1);
        do_op("or_zext", 3'd3, 32'h1000_0001, 32'hFFFF_0F0F, 3'd3, 1'b0);
        do_op("sub_sext", 3'd1, 32'h0000_0010, 32'h0000_0FFF, 3'd2, 1'b1);

        for (int i = 0; i < 30; i++) begin
            r_op = 3'($urandom_range(0, 7));
            if (r_op > 3'd5) r_op = 3'd0;
            r_w1 = (i % 3 == 0) ? 32'($urandom_range(0, 4095)) : $urandom;
            do_op($sformatf("rnd%0d", i), r_op, r_w1, $urandom, 3'($urandom), 1'($urandom));
        end

        // Response back-pressure with a pending request, then handshake and request together.
        @(negedge clk);
        op = 3'd1; word1 = 32'd5; word2 = 32'd7; len_digits = 3'd7; word2_signed = 1'b0;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t6.latency", 32'(cyc), 32'd8);
        for (int h = 0; h < 3; h++) begin
            @(posedge clk); #1;
            chk("t6.hold_ctl", {29'd0, rsp_valid, req_ready, busy}, {29'd0, 1'b1, 1'b0, 1'b1});
            chk("t6.hold_res", result, 32'hFFFF_FFFE);
            chk("t6.hold_flags", {28'd0, carry, overflow, zero, err}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("t6.handshake", {29'd0, rsp_valid, req_ready, busy}, {29'd0, 1'b0, 1'b1, 1'b0});
        @(posedge clk); #1;
        chk("t6.accept_next", {30'd0, busy, req_ready}, {30'd0, 1'b1, 1'b0});
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t6.rst_ctl", {29'd0, req_ready, rsp_valid, busy}, {29'd0, 1'b1, 1'b0, 1'b0});
        chk("t6.rst_res", result, 32'd0);
        chk("t6.rst_flags", {28'd0, carry, overflow, zero, err}, 32'd0);
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        for (int w = 0; w < 12; w++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        chk("t6.no_rsp_after_rst", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
